// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution, mispredict redirect/flush and 2-bit BHT predictor
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i, stall_i     EX holds a branch/jump; EX stalled (no accept)
//   jump_i, funct3_i     unconditional jump; branch type code
//   BrEq_i, BrLt_i       comparator flags
//   pc_i, target_i       EX instruction PC and computed target
//   pred_taken_i         prediction that travelled with the EX instruction
//   fetch_pc_i           fetch PC used for the BHT lookup
//   BrUn_o               unsigned-compare select (combinational)
//   pred_o               BHT prediction for fetch_pc_i (combinational)
//   redirect_o           one-cycle PC redirect strobe
//   redirect_pc_o        corrected PC, held between redirects
//   flush_o              kill wrong-path IF/ID instructions
//   illegal_o            accepted branch with reserved funct3
//   br_cnt_o, mis_cnt_o  saturating accept / mispredict counters
module branch_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [2:0]  funct3_i,
  input  logic        BrEq_i,
  input  logic        BrLt_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] target_i,
  input  logic        pred_taken_i,
  input  logic [31:0] fetch_pc_i,
  output logic        BrUn_o,
  output logic        pred_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        illegal_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mis_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [1:0] FL_LAST = 2'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, next_state;
  logic [1:0]      fl_cnt;
  logic [1:0]      bht [BHT_ENTRIES];
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] rd_idx;
  logic            accept;
  logic            taken;
  logic            illegal_f3;
  logic            mispredict;
  logic            unused_fetch_bits;

  assign BrUn_o  = funct3_i[2] & funct3_i[1];
  assign upd_idx = pc_i[IDX_W+1:2];
  assign rd_idx  = fetch_pc_i[IDX_W+1:2];
  // Reads the registered table, so a same-cycle update is never bypassed.
  assign pred_o  = bht[rd_idx][1];
  assign unused_fetch_bits = ^{fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0]};

  assign accept     = valid_i & ~stall_i & (state == IDLE);
  assign mispredict = accept & (taken != pred_taken_i);
  assign flush_o    = (state == FLUSH);

  always_comb begin
    taken      = 1'b0;
    illegal_f3 = 1'b0;
    if (jump_i) begin
      taken = 1'b1;
    end else begin
      case (funct3_i)
        3'b000:         taken = BrEq_i;
        3'b001:         taken = ~BrEq_i;
        3'b100, 3'b110: taken = BrLt_i;
        3'b101, 3'b111: taken = ~BrLt_i;
        default: begin
          taken      = 1'b0;
          illegal_f3 = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mispredict) next_state = FLUSH;
      FLUSH:   if (fl_cnt == FL_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      fl_cnt <= 2'd0;
    end else begin
      state  <= next_state;
      // Counts cycles spent in FLUSH; stall_i has no say here.
      fl_cnt <= (state == FLUSH) ? fl_cnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= 32'd0;
      illegal_o     <= 1'b0;
      br_cnt_o      <= 32'd0;
      mis_cnt_o     <= 32'd0;
    end else begin
      redirect_o <= mispredict;
      illegal_o  <= accept & illegal_f3;
      if (mispredict) begin
        redirect_pc_o <= taken ? target_i : pc_i + 32'd4;
      end
      if (accept && br_cnt_o != 32'hFFFF_FFFF) begin
        br_cnt_o <= br_cnt_o + 32'd1;
      end
      if (mispredict && mis_cnt_o != 32'hFFFF_FFFF) begin
        mis_cnt_o <= mis_cnt_o + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (accept) begin
      if (taken) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - scoreboard bench for branch_ctrl
module tb_branch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic        BrEq_i = 1'b0;
  logic        BrLt_i = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic [31:0] target_i = 32'd0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] fetch_pc_i = 32'h100;
  logic        BrUn_o;
  logic        pred_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        illegal_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mis_cnt_o;

  typedef struct {
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   run = 0;

  branch_ctrl #(.BHT_ENTRIES(16), .FLUSH_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .stall_i(stall_i),
    .jump_i(jump_i), .funct3_i(funct3_i), .BrEq_i(BrEq_i), .BrLt_i(BrLt_i),
    .pc_i(pc_i), .target_i(target_i), .pred_taken_i(pred_taken_i),
    .fetch_pc_i(fetch_pc_i), .BrUn_o(BrUn_o), .pred_o(pred_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .illegal_o(illegal_o), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Presents one instruction for exactly one rising edge.
  task automatic drive(input logic stall, input logic jmp, input logic [2:0] f3,
                       input logic eq, input logic lt, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pred,
                       input logic exp_redir, input logic [31:0] exp_pc,
                       input logic exp_ill);
    exp_t e;
    valid_i = 1'b1; stall_i = stall; jump_i = jmp; funct3_i = f3;
    BrEq_i = eq; BrLt_i = lt; pc_i = pc; target_i = tgt; pred_taken_i = pred;
    if (exp_redir) begin
      e.pc = exp_pc;
      e.ill = exp_ill;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk_pred(input string name, input logic [31:0] fpc, input logic want);
    fetch_pc_i = fpc;
    #1;
    chk(name, {31'd0, pred_o}, {31'd0, want});
  endtask

  // Monitor: every redirect pops one expected entry; flush runs must be 2 cycles.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      run = 0;
    end else begin
      if (redirect_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_redirect got=%h want=none", redirect_pc_o);
        end else begin
          e = exp_q.pop_front();
          if (redirect_pc_o !== e.pc || illegal_o !== e.ill) begin
            failures++;
            $display("FAIL redirect got pc=%h ill=%b want pc=%h ill=%b",
                     redirect_pc_o, illegal_o, e.pc, e.ill);
          end
        end
      end else if (illegal_o) begin
        checks++;
        failures++;
        $display("FAIL illegal_without_redirect got=1 want=0");
      end
      if (flush_o) begin
        run++;
      end else if (run != 0) begin
        chk("flush_len", run, 2);
        run = 0;
      end
    end
  end

  initial begin
    wait_neg(2);
    chk("rst_redirect", {31'd0, redirect_o}, 0);
    chk("rst_flush", {31'd0, flush_o}, 0);
    chk("rst_illegal", {31'd0, illegal_o}, 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_br_cnt", br_cnt_o, 0);
    chk("rst_mis_cnt", mis_cnt_o, 0);
    chk("rst_pred", {31'd0, pred_o}, 0);
    rst_ni = 1'b1;

    // BEQ taken, predicted not taken
    drive(0, 0, 3'b000, 1, 0, 32'h100, 32'h200, 0, 1, 32'h200, 0);
    @(negedge clk_i); chk("beq_flush1", {31'd0, flush_o}, 1);
    @(negedge clk_i); chk("beq_flush2", {31'd0, flush_o}, 1);
    @(negedge clk_i); chk("beq_flush3", {31'd0, flush_o}, 0);
    chk("beq_mis_cnt", mis_cnt_o, 1);
    chk("beq_br_cnt", br_cnt_o, 1);
    chk_pred("beq_pred", 32'h100, 1);

    // BGEU not taken, predicted taken, PC wraps
    funct3_i = 3'b111; #1; chk("brun_111", {31'd0, BrUn_o}, 1);
    funct3_i = 3'b110; #1; chk("brun_110", {31'd0, BrUn_o}, 1);
    funct3_i = 3'b100; #1; chk("brun_100", {31'd0, BrUn_o}, 0);
    drive(0, 0, 3'b111, 0, 1, 32'hFFFF_FFFC, 32'h40, 1, 1, 32'h0, 0);
    wait_neg(3);
    chk("bgeu_mis_cnt", mis_cnt_o, 2);
    chk_pred("bgeu_pred", 32'hFFFF_FFFC, 0);

    // BLT taken x3 back-to-back, then not-taken x2 to show saturation
    chk_pred("blt_pred_pre", 32'h20, 0);
    drive(0, 0, 3'b100, 0, 1, 32'h20, 32'h80, 1, 0, 0, 0);
    chk("blt_pred_after1", {31'd0, pred_o}, 1);
    drive(0, 0, 3'b100, 0, 1, 32'h20, 32'h80, 1, 0, 0, 0);
    drive(0, 0, 3'b100, 0, 1, 32'h20, 32'h80, 1, 0, 0, 0);
    chk("blt_br_cnt3", br_cnt_o, 5);
    chk("blt_pred_sat", {31'd0, pred_o}, 1);
    drive(0, 0, 3'b100, 0, 0, 32'h20, 32'h80, 0, 0, 0, 0);
    drive(0, 0, 3'b100, 0, 0, 32'h20, 32'h80, 0, 0, 0, 0);
    chk("blt_pred_dec", {31'd0, pred_o}, 0);
    chk("blt_br_cnt", br_cnt_o, 7);
    chk("blt_mis_cnt", mis_cnt_o, 2);

    // Stalled instruction is not accepted
    drive(1, 0, 3'b000, 1, 0, 32'h60, 32'h900, 0, 0, 0, 0);
    chk("stall_br_cnt", br_cnt_o, 7);

    // BNE mispredict, then mispredicts presented during FLUSH are ignored
    drive(0, 0, 3'b001, 0, 0, 32'h44, 32'h80, 0, 1, 32'h80, 0);
    drive(0, 0, 3'b000, 1, 0, 32'h48, 32'h300, 0, 0, 0, 0);
    drive(0, 0, 3'b000, 1, 0, 32'h48, 32'h300, 0, 0, 0, 0);
    wait_neg(1);
    chk("flushign_br_cnt", br_cnt_o, 8);
    chk("flushign_mis_cnt", mis_cnt_o, 3);
    chk_pred("flushign_pred", 32'h48, 0);
    chk_pred("bne_pred", 32'h44, 1);

    // Reserved funct3 predicted taken; then JAL with funct3 010
    drive(0, 0, 3'b011, 1, 1, 32'h80, 32'h500, 1, 1, 32'h84, 1);
    wait_neg(3);
    drive(0, 1, 3'b010, 0, 0, 32'h10, 32'h1000, 0, 1, 32'h1000, 0);
    wait_neg(3);
    chk("ill_br_cnt", br_cnt_o, 10);
    chk("ill_mis_cnt", mis_cnt_o, 5);
    chk("hold_redirect_pc", redirect_pc_o, 32'h1000);

    // Reset during the second flush cycle
    drive(0, 0, 3'b000, 1, 0, 32'hC, 32'h600, 0, 1, 32'h600, 0);
    @(posedge clk_i); #1;
    chk("midflush_flush_pre", {31'd0, flush_o}, 1);
    rst_ni = 1'b0;
    #1;
    chk("midflush_flush", {31'd0, flush_o}, 0);
    chk("midflush_redirect", {31'd0, redirect_o}, 0);
    chk("midflush_br_cnt", br_cnt_o, 0);
    chk("midflush_mis_cnt", mis_cnt_o, 0);
    chk("midflush_redirect_pc", redirect_pc_o, 0);
    for (int i = 0; i < 16; i++) begin
      chk_pred("midflush_pred", 32'(i * 4), 0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 3'b000, 0, 0, 32'h30, 32'h700, 0, 0, 0, 0);
    wait_neg(1);
    chk("post_rst_br_cnt", br_cnt_o, 1);
    chk("post_rst_mis_cnt", mis_cnt_o, 0);
    wait_neg(2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: BHT_ENTRIES, default 16, number of 2-bit branch-history counters; power of two, 4..64.
REQ-002 Parameter: FLUSH_CYCLES, default 2, number of cycles flush_o is held per mispredict; 1..4.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 valid_i  in  1  branch or jump instruction present in EX.
REQ-006 stall_i  in  1  EX stalled; the instruction is not accepted this cycle.
REQ-007 jump_i  in  1  unconditional jump (JAL/JALR); always taken.
REQ-008 funct3_i  in  3  branch type code.
REQ-009 BrEq_i  in  1  equal flag from branch comparator.
REQ-010 BrLt_i  in  1  less-than flag from branch comparator.
REQ-011 pc_i  in  32  PC of the EX instruction.
REQ-012 target_i  in  32  computed branch/jump target.
REQ-013 pred_taken_i  in  1  prediction carried with the EX instruction.
REQ-014 fetch_pc_i  in  32  fetch-stage PC for BHT lookup.
REQ-015 BrUn_o  out  1  unsigned-compare select to the comparator; combinational.
REQ-016 pred_o  out  1  prediction for fetch_pc_i; combinational.
REQ-017 redirect_o  out  1  one-cycle PC redirect strobe; registered.
REQ-018 redirect_pc_o  out  32  corrected PC, valid while redirect_o is high.
REQ-019 flush_o  out  1  kill younger wrong-path instructions in IF/ID.
REQ-020 illegal_o  out  1  one-cycle pulse for an accepted branch with funct3 010 or 011.
REQ-021 br_cnt_o  out  32  count of accepted branches and jumps.
REQ-022 mis_cnt_o  out  32  count of mispredicts.

Function
REQ-023 BrUn_o shall be 1 when funct3_i is 110 or 111, and 0 otherwise.
REQ-024 Accept: valid_i=1, stall_i=0, state IDLE, sampled at the rising edge.
REQ-025 taken shall be 1 when jump_i=1; otherwise per funct3_i: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 lt, 111 !lt, 010/011 not taken.
REQ-026 An accepted illegal funct3 (jump_i=0) shall pulse illegal_o for one cycle after the edge and is treated as not taken.
REQ-027 Mispredict shall be defined as (taken != pred_taken_i) on an accepted instruction.
REQ-028 FSM states: IDLE, FLUSH. IDLE->FLUSH on an accepted mispredict. FLUSH->IDLE after FLUSH_CYCLES cycles. Reset forces IDLE.
REQ-029 On mispredict, the cycle after the accept edge shall have redirect_o=1 for exactly one cycle, with redirect_pc_o = target_i if taken, else pc_i+4 (mod 2^32).
REQ-030 flush_o shall be high for exactly FLUSH_CYCLES cycles, starting the same cycle as redirect_o.
REQ-031 valid_i shall be ignored in FLUSH: no BHT update, no counts.
REQ-032 The FSM shall advance during FLUSH regardless of stall_i.
REQ-033 redirect_pc_o shall hold its last value when redirect_o=0; its reset value is 0.
REQ-034 BHT index shall be pc[log2(BHT_ENTRIES)+1:2].
REQ-035 On every accept, entry[pc_i] shall increment (taken) or decrement (not taken), saturating at 3 and 0.
REQ-036 pred_o shall be bit 1 of entry[fetch_pc_i].
REQ-037 A same-cycle update to the same index shall not bypass: pred_o returns the pre-update value.
REQ-038 br_cnt_o shall increment on each accept; mis_cnt_o shall increment on each mispredict.
REQ-039 br_cnt_o and mis_cnt_o shall saturate at 0xFFFFFFFF.
REQ-040 Back-to-back correctly predicted accepts shall be processed every cycle with no bubble.

Reset
REQ-041 While rst_ni=0: redirect_o, flush_o, illegal_o, redirect_pc_o, br_cnt_o and mis_cnt_o shall be 0, the state shall be IDLE, and all BHT entries shall be 01 (so pred_o=0).
REQ-042 Reset asserted mid-FLUSH shall immediately deassert flush_o and redirect_o; after release the block shall be in IDLE and accept on the first edge.

Verification
REQ-043 BEQ mispredict: funct3=000, BrEq=1, pred=0, pc=0x100, target=0x200 -> next cycle redirect_o=1, redirect_pc_o=0x200; flush_o high for 2 cycles; mis_cnt_o=1.
REQ-044 BGEU: funct3=111, BrLt=1, pred=1 -> BrUn_o=1; not taken; redirect_pc_o=pc+4; at pc=0xFFFFFFFC, redirect_pc_o=0x00000000.
REQ-045 Predicted correctly: BLT taken with pred=1 on 3 consecutive cycles -> no redirect; br_cnt_o=3; entry goes 01->10->11->11 (saturates); pred_o=1.
REQ-046 valid_i mispredict during FLUSH -> ignored: counters and BHT unchanged, no second redirect.
REQ-047 funct3=011 accepted with pred=1 -> illegal_o one-cycle pulse, redirect to pc+4.
REQ-048 rst_ni low in the 2nd flush cycle -> flush_o=0 immediately; counters=0; pred_o=0 for every fetch_pc_i.
